// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter granting one 3-to-8 one-hot select resource to one of
// N_REQ requesters. Grants are registered. A grant is held until the owner
// releases it or MAX_HOLD cycles elapse. Every change of owner is separated by
// a one-cycle GAP in which no grant is asserted.
module rr_decode_arbiter #(
   parameter int N_REQ    = 8,
   parameter int IDX_W    = 3,
   parameter int MAX_HOLD = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_valid,
   output logic             expired
);

   localparam int CNT_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN  = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t           state, nxt_state;
   logic [IDX_W-1:0] ptr, nxt_ptr;
   logic [CNT_W-1:0] hold_cnt, nxt_hold_cnt;
   logic [N_REQ-1:0] nxt_grant;
   logic [IDX_W-1:0] nxt_grant_idx;
   logic             nxt_expired;

   logic [IDX_W-1:0] win_idx;
   logic [IDX_W-1:0] cand;
   logic             found;
   logic             any_req;

   assign any_req     = |req;
   assign grant_valid = |grant;

   // Round-robin search: first set request after ptr, wrapping modulo N_REQ
   always_comb begin
      win_idx = '0;
      found   = 1'b0;
      cand    = '0;
      for (int unsigned i = 1; i <= N_REQ; i++) begin
         cand = ptr + IDX_W'(i);
         if (!found && req[cand]) begin
            win_idx = cand;
            found   = 1'b1;
         end
      end
   end

   // Next-state and next-output logic
   always_comb begin
      nxt_state     = state;
      nxt_ptr       = ptr;
      nxt_hold_cnt  = hold_cnt;
      nxt_grant     = grant;
      nxt_grant_idx = grant_idx;
      nxt_expired   = 1'b0;

      case (state)
         IDLE: begin
            if (en && any_req) begin
               nxt_state     = OWN;
               nxt_ptr       = win_idx;
               nxt_grant_idx = win_idx;
               nxt_grant     = N_REQ'(1) << win_idx;
               nxt_hold_cnt  = '0;
            end
         end
         OWN: begin
            // Timeout takes priority over release so a simultaneous release still flags expiry
            if (!en) begin
               nxt_state = IDLE;
               nxt_grant = '0;
            end else if (hold_cnt == HOLD_LAST) begin
               nxt_state   = GAP;
               nxt_grant   = '0;
               nxt_expired = 1'b1;
            end else if (!req[grant_idx]) begin
               nxt_state = GAP;
               nxt_grant = '0;
            end else begin
               nxt_hold_cnt = hold_cnt + 1'b1;
            end
         end
         GAP: begin
            if (en && any_req) begin
               nxt_state     = OWN;
               nxt_ptr       = win_idx;
               nxt_grant_idx = win_idx;
               nxt_grant     = N_REQ'(1) << win_idx;
               nxt_hold_cnt  = '0;
            end else begin
               nxt_state = IDLE;
            end
         end
         default: begin
            nxt_state = IDLE;
            nxt_grant = '0;
         end
      endcase
   end

   // State and registered outputs, asynchronously cleared
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= IDX_W'(N_REQ - 1);
         hold_cnt  <= '0;
         grant     <= '0;
         grant_idx <= '0;
         expired   <= 1'b0;
      end else begin
         state     <= nxt_state;
         ptr       <= nxt_ptr;
         hold_cnt  <= nxt_hold_cnt;
         grant     <= nxt_grant;
         grant_idx <= nxt_grant_idx;
         expired   <= nxt_expired;
      end
   end

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Directed bench for rr_decode_arbiter (N_REQ=8, MAX_HOLD=16) with a
// randomized invariant sweep at the end.
module tb_rr_decode_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [7:0] req;
   logic [7:0] grant;
   logic [2:0] grant_idx;
   logic       grant_valid;
   logic       expired;

   int n_chk  = 0;
   int n_pass = 0;

   rr_decode_arbiter #(
      .N_REQ    (8),
      .IDX_W    (3),
      .MAX_HOLD (16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .req         (req),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid),
      .expired     (expired)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // advance one rising edge and settle just after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      en  = 1'b0;
      req = '0;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic chk_grant(input string tag, input logic [7:0] g, input logic [2:0] idx);
      chk({tag, "_grant"}, 32'(grant), 32'(g));
      if (g != 8'h00) chk({tag, "_idx"}, 32'(grant_idx), 32'(idx));
      chk({tag, "_valid"}, 32'(grant_valid), 32'(g != 8'h00));
   endtask

   initial begin
      logic [7:0] g;
      int         bad;

      // 1: reset state, first grant, async reset mid-grant
      rst = 1'b1; en = 1'b0; req = '0;
      tick(); tick();
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_idx", 32'(grant_idx), 32'h0);
      chk("rst_valid", 32'(grant_valid), 32'h0);
      chk("rst_expired", 32'(expired), 32'h0);
      rst = 1'b0; tick();
      en = 1'b1; req = 8'h01;
      tick();
      chk_grant("t1_first", 8'h01, 3'd0);
      #3 rst = 1'b1;
      #1;
      chk("t1_async_grant", 32'(grant), 32'h0);
      chk("t1_async_valid", 32'(grant_valid), 32'h0);
      chk("t1_async_exp", 32'(expired), 32'h0);
      tick();
      rst = 1'b0;
      tick();
      chk_grant("t1_regrant", 8'h01, 3'd0);

      // 2: full rotation with one-cycle release per owner
      do_reset();
      en = 1'b1; req = 8'hFF;
      tick();
      for (int k = 0; k < 9; k++) begin
         g = 8'h01 << (k % 8);
         chk_grant($sformatf("t2_own%0d", k), g, 3'(k % 8));
         tick(); tick();
         chk("t2_held", 32'(grant), 32'(g));
         req = 8'hFF & ~g;
         tick();
         chk("t2_gap", 32'(grant), 32'h0);
         chk("t2_gap_exp", 32'(expired), 32'h0);
         req = 8'hFF;
         tick();
      end

      // 3: lone holder times out after 16 cycles, then regranted
      do_reset();
      en = 1'b1; req = 8'h10;
      tick();
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("t3_hold%0d", i), 32'(grant), 32'h10);
         chk("t3_noexp", 32'(expired), 32'h0);
         tick();
      end
      chk("t3_gap", 32'(grant), 32'h0);
      chk("t3_expired", 32'(expired), 32'h1);
      tick();
      chk_grant("t3_regrant", 8'h10, 3'd4);
      chk("t3_exp_clr", 32'(expired), 32'h0);

      // 4: rotation between owners 2 and 5
      do_reset();
      en = 1'b1; req = 8'h04;
      tick();
      chk_grant("t4_own2", 8'h04, 3'd2);
      req = 8'h24;
      tick();
      chk_grant("t4_keep2", 8'h04, 3'd2);
      req = 8'h20;
      tick();
      chk("t4_gap1", 32'(grant), 32'h0);
      req = 8'h24;
      tick();
      chk_grant("t4_own5", 8'h20, 3'd5);
      req = 8'h04;
      tick();
      chk("t4_gap2", 32'(grant), 32'h0);
      req = 8'h24;
      tick();
      chk_grant("t4_back2", 8'h04, 3'd2);

      // 5: enable drop forces idle, re-enable regrants
      do_reset();
      en = 1'b1; req = 8'h08;
      tick();
      chk_grant("t5_own3", 8'h08, 3'd3);
      en = 1'b0;
      tick();
      chk_grant("t5_en_off", 8'h00, 3'd0);
      chk("t5_noexp", 32'(expired), 32'h0);
      tick();
      chk("t5_idle", 32'(grant), 32'h0);
      en = 1'b1;
      tick();
      chk_grant("t5_regrant", 8'h08, 3'd3);

      // 6: release on the final hold cycle counts as a timeout
      do_reset();
      en = 1'b1; req = 8'h02;
      tick();
      chk_grant("t6_own1", 8'h02, 3'd1);
      for (int i = 0; i < 15; i++) tick();
      chk("t6_last", 32'(grant), 32'h02);
      req = 8'h00;
      tick();
      chk("t6_gap", 32'(grant), 32'h0);
      chk("t6_expired", 32'(expired), 32'h1);
      tick();
      chk("t6_idle", 32'(grant), 32'h0);
      chk("t6_exp_clr", 32'(expired), 32'h0);

      // randomized invariant sweep
      do_reset();
      bad = 0;
      for (int c = 0; c < 10000; c++) begin
         en  = ($urandom_range(0, 15) != 0);
         req = 8'($urandom);
         tick();
         if ((grant & (grant - 8'h01)) != 8'h00) bad++;
         if (grant_valid !== (grant != 8'h00)) bad++;
         if (grant_valid && (grant !== (8'h01 << grant_idx))) bad++;
         if (expired && grant_valid) bad++;
      end
      chk("rand_invariants", 32'(bad), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
